// File: rtl/frame_window_reader_pkg.sv
// Shared types for the frame window reader: stream markers and FSM state encodings.
package FrameReaderTypes;

    localparam logic [16:0] FRAME_START = 17'h10000;
    localparam logic [16:0] ROW_START   = 17'h10001;
    localparam logic [16:0] FRAME_END   = 17'h1FFFF;

    typedef enum logic [1:0] {
        F_IDLE,
        F_CMD,
        F_RECV
    } fetch_state_t;

    typedef enum logic [2:0] {
        E_IDLE,
        E_FSTART,
        E_RSTART,
        E_PIX,
        E_FEND
    } emit_state_t;

    function automatic logic [16:0] pixel_word(input logic [15:0] px);
        return {1'b0, px};
    endfunction

endpackage

// File: rtl/pixel_unpack_fifo.sv
// Pixel buffer: accepts up to two 16-bit pixels per 32-bit beat (per-half keep mask),
// delivers one pixel per read, and flags when a whole burst of space is free.
module pixel_unpack_fifo
    import FrameReaderTypes::*;
#(
    parameter int BURST_WORDS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_keep,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        empty,
    output logic        room
);

    localparam int DEPTH = 4 * BURST_WORDS;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_hi;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    n_wr;
    logic          rd_fire;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] inc);
        int s;
        s = int'(p) + int'(inc);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign n_wr      = wr_en ? ({1'b0, wr_keep[0]} + {1'b0, wr_keep[1]}) : 2'd0;
    // A lone high pixel lands in the slot the low pixel would have used.
    assign wr_ptr_hi = wr_keep[0] ? ptr_add(wr_ptr, 2'd1) : wr_ptr;
    assign rd_fire   = rd_en && !empty;
    assign rd_data   = mem[rd_ptr];
    assign empty     = (count == '0);
    assign room      = (count <= CW'(2 * BURST_WORDS));

    always_ff @(posedge clk) begin
        if (wr_en && wr_keep[0]) mem[wr_ptr]    <= wr_data[15:0];
        if (wr_en && wr_keep[1]) mem[wr_ptr_hi] <= wr_data[31:16];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= ptr_add(wr_ptr, n_wr);
            if (rd_fire) rd_ptr <= ptr_add(rd_ptr, 2'd1);
            count  <= count + CW'(n_wr) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/frame_window_reader.sv
// Burst-reads a window of one SDRAM frame slot and emits it as a marker-framed 17-bit stream.
// Optional FRAME_READER_DECIM2_EN adds a 'decim' input for 2x2 decimation of the window.
module frame_window_reader
    import FrameReaderTypes::*;
#(
    parameter int ADDR_WIDTH   = 21,
    parameter int BURST_WORDS  = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int SLOT_GAP     = 32,
    parameter int NUM_SLOTS    = 3,
    parameter int DIM_WIDTH    = 11
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         init_done,
    input  logic                         start,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot,
    input  logic [DIM_WIDTH-1:0]         win_x,
    input  logic [DIM_WIDTH-1:0]         win_y,
    input  logic [DIM_WIDTH-1:0]         win_w,
    input  logic [DIM_WIDTH-1:0]         win_h,
`ifdef FRAME_READER_DECIM2_EN
    input  logic                         decim,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         cmd,
    output logic                         cmd_en,
    output logic [ADDR_WIDTH-1:0]        addr,
    input  logic [31:0]                  rd_data,
    input  logic                         rd_data_valid,
    output logic [16:0]                  out_data,
    output logic                         out_wr_en,
    input  logic                         out_full
);

    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int DW1       = DIM_WIDTH + 1;
    localparam int BEAT_W    = $clog2(BURST_WORDS + 1);
    localparam int BURST_PIX = 2 * BURST_WORDS;
    localparam int SLOT_SIZE = FRAME_WIDTH * FRAME_HEIGHT + SLOT_GAP;

    fetch_state_t           f_state;
    emit_state_t            e_state;

    logic                   decim_in;
    logic [DIM_WIDTH-1:0]   w_out;
    logic [DIM_WIDTH-1:0]   h_out;
    logic [DW1-1:0]         x_end;
    logic [DW1-1:0]         y_end;
    logic                   bad_window;
    logic                   req;
    logic                   accept;
    logic                   reject;
    logic                   stray;
    logic [ADDR_WIDTH-1:0]  start_addr;

    logic [DIM_WIDTH-1:0]   out_w_q;
    logic [DIM_WIDTH-1:0]   out_h_q;
    logic [DIM_WIDTH-1:0]   row_w_q;
    logic                   decim_q;
    logic [ADDR_WIDTH-1:0]  stride;

    logic [ADDR_WIDTH-1:0]  row_addr;
    logic [DW1-1:0]         col;
    logic [DW1-1:0]         next_col;
    logic [DW1-1:0]         beat_idx;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [DIM_WIDTH-1:0]   f_row;

    logic                   e_arm;
    logic [DIM_WIDTH-1:0]   pix_cnt;
    logic [DIM_WIDTH-1:0]   e_row;
    logic                   word_ready;
    logic                   end_fire;

    logic                   fifo_wr;
    logic [1:0]             fifo_keep;
    logic                   fifo_rd;
    logic [15:0]            fifo_data;
    logic                   fifo_empty;
    logic                   fifo_room;

`ifdef FRAME_READER_DECIM2_EN
    assign decim_in = decim;
`else
    assign decim_in = 1'b0;
`endif

    assign w_out      = decim_in ? (win_w >> 1) : win_w;
    assign h_out      = decim_in ? (win_h >> 1) : win_h;
    assign x_end      = {1'b0, win_x} + {1'b0, win_w};
    assign y_end      = {1'b0, win_y} + {1'b0, win_h};
    // Zero output size covers both an empty window and one that decimates to nothing.
    assign bad_window = (w_out == '0) || (h_out == '0)
                     || (x_end > DW1'(FRAME_WIDTH))
                     || (y_end > DW1'(FRAME_HEIGHT))
                     || ({1'b0, slot} >= (SLOT_W + 1)'(NUM_SLOTS));
    assign req        = start && init_done && !busy;
    assign accept     = req && !bad_window;
    assign reject     = req && bad_window;
    assign stray      = rd_data_valid && (f_state != F_RECV);

    assign start_addr = ADDR_WIDTH'(SLOT_SIZE) * ADDR_WIDTH'(slot)
                      + ADDR_WIDTH'(FRAME_WIDTH) * ADDR_WIDTH'(win_y)
                      + ADDR_WIDTH'(win_x);
    assign stride     = decim_q ? ADDR_WIDTH'(2 * FRAME_WIDTH) : ADDR_WIDTH'(FRAME_WIDTH);
    assign cmd        = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
                err  <= 1'b0;
            end
            if (reject) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
            if (end_fire) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (stray) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            out_w_q <= w_out;
            out_h_q <= h_out;
            row_w_q <= win_w;
            decim_q <= decim_in;
        end
    end

    // Fetch side: one burst in flight, each burst only once a full burst of buffer space is free.
    assign next_col  = col + DW1'(BURST_PIX);
    assign beat_idx  = col + DW1'({beat_cnt, 1'b0});
    assign fifo_wr   = rd_data_valid && (f_state == F_RECV);
    assign fifo_keep[0] = decim_q ? ((beat_idx + DW1'(1)) < {1'b0, row_w_q})
                                  : (beat_idx < {1'b0, row_w_q});
    assign fifo_keep[1] = !decim_q && ((beat_idx + DW1'(1)) < {1'b0, row_w_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_state  <= F_IDLE;
            cmd_en   <= 1'b0;
            addr     <= '0;
            row_addr <= '0;
            col      <= '0;
            beat_cnt <= '0;
            f_row    <= '0;
        end else begin
            cmd_en <= 1'b0;
            case (f_state)
                F_IDLE: begin
                    if (accept) begin
                        row_addr <= start_addr;
                        col      <= '0;
                        f_row    <= '0;
                        f_state  <= F_CMD;
                    end
                end
                F_CMD: begin
                    if (fifo_room) begin
                        cmd_en   <= 1'b1;
                        addr     <= row_addr + ADDR_WIDTH'(col);
                        beat_cnt <= '0;
                        f_state  <= F_RECV;
                    end
                end
                F_RECV: begin
                    if (rd_data_valid) begin
                        if (beat_cnt == BEAT_W'(BURST_WORDS - 1)) begin
                            f_state <= F_CMD;
                            if (next_col >= {1'b0, row_w_q}) begin
                                col      <= '0;
                                row_addr <= row_addr + stride;
                                f_row    <= f_row + 1'b1;
                                if (f_row == out_h_q - 1'b1) f_state <= F_IDLE;
                            end else begin
                                col <= next_col;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: f_state <= F_IDLE;
            endcase
        end
    end

    pixel_unpack_fifo #(
        .BURST_WORDS (BURST_WORDS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_keep (fifo_keep),
        .wr_data (rd_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .room    (fifo_room)
    );

    // Emit side: the arm cycle delays the frame-start marker to line up with the first command.
    always_comb begin
        out_data   = '0;
        word_ready = 1'b0;
        case (e_state)
            E_FSTART: begin
                out_data   = FRAME_START;
                word_ready = 1'b1;
            end
            E_RSTART: begin
                out_data   = ROW_START;
                word_ready = 1'b1;
            end
            E_PIX: begin
                out_data   = pixel_word(fifo_data);
                word_ready = !fifo_empty;
            end
            E_FEND: begin
                out_data   = FRAME_END;
                word_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_wr_en = word_ready && !out_full;
    assign fifo_rd   = out_wr_en && (e_state == E_PIX);
    assign end_fire  = out_wr_en && (e_state == E_FEND);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_state <= E_IDLE;
            e_arm   <= 1'b0;
            pix_cnt <= '0;
            e_row   <= '0;
        end else begin
            e_arm <= accept;
            case (e_state)
                E_IDLE: begin
                    if (e_arm) begin
                        e_row   <= '0;
                        e_state <= E_FSTART;
                    end
                end
                E_FSTART: if (out_wr_en) e_state <= E_RSTART;
                E_RSTART: begin
                    if (out_wr_en) begin
                        pix_cnt <= '0;
                        e_state <= E_PIX;
                    end
                end
                E_PIX: begin
                    if (out_wr_en) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == out_w_q - 1'b1) begin
                            if (e_row == out_h_q - 1'b1) begin
                                e_state <= E_FEND;
                            end else begin
                                e_row   <= e_row + 1'b1;
                                e_state <= E_RSTART;
                            end
                        end
                    end
                end
                E_FEND: if (out_wr_en) e_state <= E_IDLE;
                default: e_state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_window_reader.md
# frame_window_reader

Reads a rectangular window of 16-bit pixels out of one of several SDRAM frame slots with burst reads, and emits it as a framed 17-bit stream into the LCD-side FIFO. It sits between the SDRAM controller command port and the display output queue, and supersedes the fixed-size packed-frame reader. Window origin, size and slot are chosen at runtime per frame; burst length and frame geometry are parameters.

## Interface
- `ADDR_WIDTH`, 21: memory address width, in pixel (16-bit) units.
- `BURST_WORDS`, 8: 32-bit beats per read burst; each burst returns `2*BURST_WORDS` pixels.
- `FRAME_WIDTH`, 640: stored frame width and row stride, in pixels.
- `FRAME_HEIGHT`, 480: stored frame height.
- `SLOT_GAP`, 32: padding in pixels between consecutive slots.
- `NUM_SLOTS`, 3: number of frame slots.
- `DIM_WIDTH`, 11: width of window coordinate and size fields.
- `clk  in  1`: clock.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `init_done  in  1`: memory ready; `start` is ignored while low.
- `start  in  1`: one-cycle request; window inputs are sampled on this cycle.
- `slot  in  $clog2(NUM_SLOTS)`: frame slot index.
- `win_x`, `win_y`, `win_w`, `win_h  in  DIM_WIDTH`: window origin and size.
- `busy  out  1`: frame in progress.
- `done  out  1`: one-cycle pulse after the frame-end marker is written.
- `err  out  1`: sticky; set by a rejected start or a stray beat, cleared by an accepted start.
- `cmd  out  1`: 0 = read (always 0).
- `cmd_en  out  1`: one-cycle command strobe.
- `addr  out  ADDR_WIDTH`: burst start address.
- `rd_data  in  32`: beat; low half is pixel `addr+2k`, high half is `addr+2k+1`.
- `rd_data_valid  in  1`: beat valid.
- `out_data  out  17`: stream word.
- `out_wr_en  out  1`: FIFO write.
- `out_full  in  1`: FIFO full.

## Operation
- Slot base address = `slot*(FRAME_WIDTH*FRAME_HEIGHT+SLOT_GAP)`. Row `r` starts at base + `(win_y+r)*FRAME_WIDTH + win_x`.
- Stream format: `0x10000` frame start. Then, for each row: `0x10001` row start followed by `win_w` words of `{1'b0,pixel}`. Finally `0x1FFFF` frame end.
- Start is rejected when any of these hold: `win_w==0`, `win_h==0`, `win_x+win_w>FRAME_WIDTH`, `win_y+win_h>FRAME_HEIGHT`, `slot>=NUM_SLOTS`. On reject: `err` is set, `done` pulses, and nothing is emitted. `start` while `busy` is ignored.
- Fetch FSM: IDLE -> CMD (issue `cmd_en`) -> RECV (count exactly `BURST_WORDS` beats).
  - After RECV, go to CMD for the next burst of the row, CMD for the next row, or IDLE at the end of the frame.
  - Each row needs `ceil(win_w/(2*BURST_WORDS))` bursts. Pixels past `win_w` in the last burst are discarded and never cross a row boundary.
  - Only one burst is outstanding at a time. CMD waits until the pixel buffer has room for `2*BURST_WORDS` pixels.
- Emit FSM: IDLE -> FSTART -> RSTART -> PIX (`win_w` words) -> RSTART, or FEND after the last row -> IDLE. `done` pulses on the FEND write.
- Pixel buffer holds `4*BURST_WORDS` pixels, written two per beat, read one per cycle.
- Any `rd_data_valid` outside RECV sets `err` and is dropped.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `cmd=0`, `cmd_en=0`, `addr=0`, `out_wr_en=0`, `out_data=0`. Both FSMs return to IDLE and the pixel buffer is emptied.
- Reset mid-frame aborts the frame without emitting `0x1FFFF`. Beats arriving after reset count as stray and set `err`.
- Accepted start: `busy` rises the next cycle. `0x10000` is written on cycle start+2 if `out_full` is low. The first `cmd_en` is on start+2.
- `out_wr_en` is asserted only in a cycle where `out_full==0`, the emit FSM has a word ready, and, for pixel words, the buffer is non-empty. Throughput is 1 word per cycle.
- Beats may be non-consecutive. A beat arriving in the same cycle the buffer is read must be accepted, with no loss.
- `busy` falls in the cycle `done` pulses.

## Configuration
- `FRAME_READER_DECIM2_EN` defined: adds a `decim` input (1 bit), sampled at start.
  - With `decim=1`, only even rows of the window are fetched and only even pixels (window-relative) are emitted.
  - Output size is `floor(win_w/2)` x `floor(win_h/2)`. A zero output dimension is treated as a reject.
- Macro undefined: the port is absent and the full window is always emitted.

## Structure
- Shared package `FrameReaderTypes`: marker constants `FRAME_START=17'h10000`, `ROW_START=17'h10001`, `FRAME_END=17'h1FFFF`; the fetch and emit state enums.
- Sub-module `pixel_unpack_fifo`: 32-bit write, 16-bit read, depth `4*BURST_WORDS` pixels, with a `free >= 2*BURST_WORDS` flag.

## Test plan
- Slot 1, window (0,0,23,17), random memory, `BURST_WORDS=8`:
  - `addr` of the first burst = 0x4B020.
  - Stream is `0x10000`, then 17×(`0x10001` + 23 pixels) with row r read from 0x4B020 + r*640, then `0x1FFFF`.
  - `done` pulses once.
- Window (5,3,16,2), slot 0: exactly 2 bursts, at 0x785 and 0xA05. All 16 pixels of each burst are emitted.
- `out_full` toggled randomly at 50% during the frame: the stream content is unchanged, and no `out_wr_en` occurs while `out_full=1`.
- Start with `win_x=630`, `win_w=20`: `err=1`, one `done` pulse, zero `cmd_en`, zero `out_wr_en`.
- `rd_data_valid` pulse in IDLE: `err=1`. A following valid start clears it and runs normally.
- With `FRAME_READER_DECIM2_EN` and `decim=1`, window (0,0,8,4): 2 rows of 4 pixels each, taken from rows 0 and 2 at x=0,2,4,6.
